instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | instr_fetch: FILL/RUN/HALT fetch stage feeding decode from a 1-cycle IM.  |
// | Optional perf counters compiled in with `define IF_PERF_CNT_EN.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_IM_ID,
  input  logic        flow_change_ID_EX,
  input  logic [15:0] dst_ID_EX,
  input  logic        hlt_DM_WB,
  input  logic [16:0] im_rdata,
  output logic [15:0] im_addr,
  output logic        im_rd_en,
  output logic [16:0] instr,
  output logic [15:0] nxt_pc,
  output logic [1:0]  fetch_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt,
  output logic [15:0] redir_cnt
`endif
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [16:0] BUBBLE = 17'h00000;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_w;

  // pc always tracks the address issued this cycle, so it names the word on im_rdata next cycle.
  always_comb begin
    state_d = state_q;
    addr_w  = pc_q;
    unique case (state_q)
      FILL: begin
        addr_w  = pc_q;
        state_d = RUN;
      end
      RUN: begin
        if (hlt_DM_WB) begin
          addr_w  = pc_q;
          state_d = HALT;
        end else if (flow_change_ID_EX) begin
          addr_w = dst_ID_EX;
        end else if (stall_IM_ID) begin
          addr_w = pc_q;
        end else begin
          addr_w = pc_q + 16'd1;
        end
      end
      HALT: begin
        addr_w  = pc_q;
        state_d = HALT;
      end
      default: begin
        addr_w  = pc_q;
        state_d = FILL;
      end
    endcase
    pc_d = addr_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      pc_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Reset forces the post-reset FILL view even when the old state was RUN or HALT.
  always_comb begin
    im_addr     = rst ? 16'h0000 : addr_w;
    im_rd_en    = rst || (state_q != HALT);
    instr       = (!rst && (state_q == RUN)) ? im_rdata : BUBBLE;
    nxt_pc      = rst ? 16'h0001 : (pc_q + 16'd1);
    fetch_state = state_q;
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;
  logic        in_run_w;

  always_comb begin
    in_run_w    = (state_q == RUN);
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (in_run_w && !stall_IM_ID && (fetch_cnt_q != 16'hFFFF))
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (in_run_w && stall_IM_ID && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (in_run_w && flow_change_ID_EX && (redir_cnt_q != 16'hFFFF))
      redir_cnt_d = redir_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
      redir_cnt_q <= 16'h0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign redir_cnt = redir_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_instr_fetch: randomized scoreboard bench for instr_fetch.              |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_IM_ID = 1'b0;
  logic        flow_change_ID_EX = 1'b0;
  logic [15:0] dst_ID_EX = 16'h0000;
  logic        hlt_DM_WB = 1'b0;
  logic [16:0] im_rdata = 17'h00000;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [16:0] instr;
  logic [15:0] nxt_pc;
  logic [1:0]  fetch_state;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt, redir_cnt;
`endif

  instr_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .stall_IM_ID       (stall_IM_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dst_ID_EX         (dst_ID_EX),
    .hlt_DM_WB         (hlt_DM_WB),
    .im_rdata          (im_rdata),
    .im_addr           (im_addr),
    .im_rd_en          (im_rd_en),
    .instr             (instr),
    .nxt_pc            (nxt_pc),
    .fetch_state       (fetch_state)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt         (fetch_cnt),
    .stall_cnt         (stall_cnt),
    .redir_cnt         (redir_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents; bit 16 varies so the full word is exercised.
  function automatic logic [16:0] memval(input logic [15:0] a);
    return {a[3] ^ a[11], a};
  endfunction

  // One-cycle-latency instruction memory; garbage when not read.
  always @(posedge clk) begin
    if (im_rd_en) im_rdata <= memval(im_addr);
    else          im_rdata <= 17'($urandom);
  end

  typedef struct {
    logic        r;
    logic        known;
    logic [15:0] addr;
    logic        rd;
    logic [16:0] ins;
    logic [15:0] nxt;
    logic [1:0]  st;
    logic [15:0] fc, sc, rc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: presented address, fetch mode, event tallies.
  int          mode = 0;   // 0 filling, 1 running, 2 halted
  logic [15:0] mpc = 16'h0000;
  int          mfc = 0, msc = 0, mrc = 0;
  logic        mknown = 1'b0;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic cyc(input logic r, input logic s, input logic f,
                     input logic [15:0] d, input logic h);
    exp_t        e;
    logic [15:0] a;
    @(negedge clk);
    rst = r; stall_IM_ID = s; flow_change_ID_EX = f; dst_ID_EX = d; hlt_DM_WB = h;
    #1;
    e.r = r; e.known = mknown;
    e.fc = 16'(mfc); e.sc = 16'(msc); e.rc = 16'(mrc);
    a = mpc;
    if (mode == 1) begin
      if (h)      a = mpc;
      else if (f) a = d;
      else if (s) a = mpc;
      else        a = mpc + 16'd1;
    end
    if (r) begin
      e.addr = 16'h0000; e.rd = 1'b1; e.ins = 17'h0; e.nxt = 16'h0001; e.st = 2'd0;
    end else begin
      e.addr = a;
      e.rd   = (mode != 2);
      e.ins  = (mode == 1) ? memval(mpc) : 17'h0;
      e.nxt  = mpc + 16'd1;
      e.st   = 2'(mode);
    end
    q.push_back(e);
    if (r) begin
      mode = 0; mpc = 16'h0000; mfc = 0; msc = 0; mrc = 0; mknown = 1'b1;
    end else begin
      if (mode == 1) begin
        if (s) msc = sat_inc(msc); else mfc = sat_inc(mfc);
        if (f) mrc = sat_inc(mrc);
      end
      if (mode == 0) mode = 1;
      else if (mode == 1 && h) mode = 2;
      mpc = a;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle once the DUT outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("im_addr",  32'(im_addr),  32'(e.addr));
        chk("im_rd_en", 32'(im_rd_en), 32'(e.rd));
        chk("instr",    32'(instr),    32'(e.ins));
        chk("nxt_pc",   32'(nxt_pc),   32'(e.nxt));
        if (!e.r) chk("fetch_state", 32'(fetch_state), 32'(e.st));
`ifdef IF_PERF_CNT_EN
        if (e.known) begin
          chk("fetch_cnt", 32'(fetch_cnt), 32'(e.fc));
          chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
          chk("redir_cnt", 32'(redir_cnt), 32'(e.rc));
        end
`endif
      end
    end
  end

  initial begin
    int guard;
    cyc(1, 0, 0, 16'h0, 0);
    cyc(1, 1, 1, 16'h1234, 1);
    // Fill then sequential fetch up to the word at address 5.
    cyc(0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 16'h0, 0);
    // Stall three cycles while address 5 is presented.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    guard = 0;
    while (mpc != 16'h0008 && guard < 20) begin cyc(0, 0, 0, 16'h0, 0); guard++; end
    cyc(0, 0, 1, 16'h0040, 0);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    // Redirect together with stall: redirect wins.
    cyc(0, 1, 1, 16'h0020, 0);
    cyc(0, 1, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    // Wrap past 0xFFFF, then halt with competing inputs.
    cyc(0, 0, 1, 16'hFFFE, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 1, 1, 16'h0077, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    // Reset out of HALT, and reset mid-stall / mid-redirect.
    cyc(1, 1, 1, 16'h5555, 1);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 1, 0, 16'h0, 0);
    cyc(1, 1, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 1, 16'h0100, 0);
    cyc(1, 0, 1, 16'h0200, 0);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      cyc($urandom_range(0, 149) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0,
          d,
          $urandom_range(0, 199) == 0);
    end
`ifdef IF_PERF_CNT_EN
    // Saturate the fetch counter, then clear it with reset.
    cyc(1, 0, 0, 16'h0, 0);
    for (int i = 0; i < 70001; i++) cyc(0, 0, 0, 16'h0, 0);
    cyc(1, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
`endif
    @(negedge clk);
    #5;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left, 0 required", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
